// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap/xRET sequencer: state encoding, privilege
// levels, CSR addresses, cause codes, mstatus field positions, interrupt
// priority order and the mstatus update helpers.
package trap_sequencer_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_W_EPC    = 3'd1;
    localparam logic [2:0] ST_W_CAUSE  = 3'd2;
    localparam logic [2:0] ST_W_TVAL   = 3'd3;
    localparam logic [2:0] ST_W_STATUS = 3'd4;
    localparam logic [2:0] ST_REDIRECT = 3'd5;

    // Privilege levels
    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    // CSR addresses touched by the sequencer
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    // Exception cause used when an xRET is not permitted
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;

    // mstatus bit positions
    localparam int MS_SIE    = 1;
    localparam int MS_MIE    = 3;
    localparam int MS_SPIE   = 5;
    localparam int MS_MPIE   = 7;
    localparam int MS_SPP    = 8;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    // Interrupt priority, highest first: MEI, MSI, MTI, SEI, SSI, STI
    localparam int IRQ_COUNT = 6;
    localparam logic [3:0] IRQ_PRIO [IRQ_COUNT] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

    // Low half of mstatus after trap entry into M (to_s=0) or S (to_s=1)
    function automatic logic [15:0] mstatus_trap(input logic [15:0] st,
                                                 input logic        to_s,
                                                 input logic [1:0]  mode);
        logic [15:0] r;
        r = st;
        if (to_s) begin
            r[MS_SPIE] = st[MS_SIE];
            r[MS_SIE]  = 1'b0;
            r[MS_SPP]  = mode[0];
        end else begin
            r[MS_MPIE]              = st[MS_MIE];
            r[MS_MIE]               = 1'b0;
            r[MS_MPP_HI:MS_MPP_LO]  = mode;
        end
        return r;
    endfunction

    // Low half of mstatus after a legal MRET (is_mret=1) or SRET
    function automatic logic [15:0] mstatus_xret(input logic [15:0] st,
                                                 input logic        is_mret);
        logic [15:0] r;
        r = st;
        if (is_mret) begin
            r[MS_MIE]              = st[MS_MPIE];
            r[MS_MPIE]             = 1'b1;
            r[MS_MPP_HI:MS_MPP_LO] = 2'b00;
        end else begin
            r[MS_SIE]  = st[MS_SPIE];
            r[MS_SPIE] = 1'b1;
            r[MS_SPP]  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/trap_irq_sel.sv
// Picks the highest-priority pending, enabled interrupt and the privilege
// level that will service it. Purely combinational.
module trap_irq_sel
    import trap_sequencer_pkg::*;
(
    input  logic [15:0] mip,
    input  logic [15:0] mie,
    input  logic [15:0] mideleg,
    input  logic        mstatus_mie,
    input  logic        mstatus_sie,
    input  logic [1:0]  cur_mode,
    output logic        valid,
    output logic [3:0]  code,
    output logic [1:0]  target
);

    logic        m_ok_s;
    logic        s_ok_s;
    logic [15:0] en_s;

    // Filter pending bits by their per-level global enable, then scan lowest to highest priority so the top one wins
    always_comb begin
        m_ok_s = (cur_mode != PRIV_M) | mstatus_mie;
        s_ok_s = (cur_mode == PRIV_U) | ((cur_mode == PRIV_S) & mstatus_sie);
        en_s   = (mip & mie) & ((mideleg & {16{s_ok_s}}) | (~mideleg & {16{m_ok_s}}));
        valid  = 1'b0;
        code   = 4'd0;
        target = PRIV_M;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (en_s[IRQ_PRIO[i]]) begin
                valid  = 1'b1;
                code   = IRQ_PRIO[i];
                target = mideleg[IRQ_PRIO[i]] ? PRIV_S : PRIV_M;
            end else begin
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap/xRET controller: accepts one exception, interrupt or xRET at a time,
// writes the trap CSRs through the shared CSR write port and finishes with a
// one-cycle fetch redirect and privilege change.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            xret_valid,
    input  logic            xret_is_mret,
    input  logic            int_window,
    input  logic [XLEN-1:0] epc,
    input  logic [1:0]      cur_mode,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic [15:0]     medeleg,
    input  logic [15:0]     mideleg,
    input  logic [15:0]     mip,
    input  logic [15:0]     mie,
    output logic            ev_ack,
    output logic            busy,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic            csr_wready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      next_mode
);

    logic [2:0]      state_r, state_nx_s;
    logic            busy_r;
    logic            csr_wen_r, wen_nx_s;
    logic [11:0]     csr_waddr_r, waddr_nx_s;
    logic [XLEN-1:0] csr_wdata_r, wdata_nx_s;
    logic            redirect_valid_r, rv_nx_s;
    logic [XLEN-1:0] redirect_pc_r, rpc_nx_s;
    logic [1:0]      next_mode_r, mode_nx_s;

    // Event snapshot taken at acceptance
    logic            tgt_s_r;
    logic [XLEN-1:0] cause_r, tval_r, status_r, rpc_r;
    logic [1:0]      nmode_r;

    logic            irq_valid_s;
    logic [3:0]      irq_code_s;
    logic [1:0]      irq_target_s;

    logic            xret_illegal_s, any_event_s, accept_s, grant_s;
    logic            acc_xret_s, acc_irq_s, acc_tgt_s_s;
    logic [3:0]      acc_code_s;
    logic [XLEN-1:0] acc_tval_s, acc_cause_s, acc_status_s, acc_rpc_s, acc_tvec_s;
    logic [1:0]      acc_mode_s;

    trap_irq_sel u_irq_sel (
        .mip         (mip),
        .mie         (mie),
        .mideleg     (mideleg),
        .mstatus_mie (mstatus[MS_MIE]),
        .mstatus_sie (mstatus[MS_SIE]),
        .cur_mode    (cur_mode),
        .valid       (irq_valid_s),
        .code        (irq_code_s),
        .target      (irq_target_s)
    );

    // Classify the incoming event by priority and compute everything the sequence will need
    always_comb begin
        acc_xret_s   = 1'b0;
        acc_irq_s    = 1'b0;
        acc_tgt_s_s  = 1'b0;
        acc_code_s   = 4'd0;
        acc_tval_s   = {XLEN{1'b0}};
        xret_illegal_s = xret_is_mret ? (cur_mode != PRIV_M) : (cur_mode == PRIV_U);
        any_event_s  = exc_valid | xret_valid | (int_window & irq_valid_s);
        accept_s     = (state_r == ST_IDLE) & any_event_s;
        grant_s      = csr_wen_r & csr_wready;

        if (exc_valid) begin
            acc_code_s  = exc_code;
            acc_tval_s  = exc_tval;
            acc_tgt_s_s = (cur_mode != PRIV_M) & medeleg[exc_code];
        end else if (xret_valid & xret_illegal_s) begin
            acc_code_s  = CAUSE_ILLEGAL_INSTR;
            acc_tgt_s_s = (cur_mode != PRIV_M) & medeleg[CAUSE_ILLEGAL_INSTR];
        end else if (xret_valid) begin
            acc_xret_s  = 1'b1;
        end else if (int_window & irq_valid_s) begin
            acc_irq_s   = 1'b1;
            acc_code_s  = irq_code_s;
            acc_tgt_s_s = (irq_target_s == PRIV_S);
        end else begin
            acc_code_s  = 4'd0;
        end

        if (acc_irq_s) begin
            acc_cause_s = {1'b1, {(XLEN-5){1'b0}}, acc_code_s};
        end else begin
            acc_cause_s = {{(XLEN-4){1'b0}}, acc_code_s};
        end

        acc_tvec_s = acc_tgt_s_s ? stvec : mtvec;

        if (acc_xret_s) begin
            acc_status_s = {mstatus[XLEN-1:16], mstatus_xret(mstatus[15:0], xret_is_mret)};
            if (xret_is_mret) begin
                acc_rpc_s  = mepc;
                acc_mode_s = mstatus[MS_MPP_HI:MS_MPP_LO];
            end else begin
                acc_rpc_s  = sepc;
                acc_mode_s = {1'b0, mstatus[MS_SPP]};
            end
        end else begin
            acc_status_s = {mstatus[XLEN-1:16], mstatus_trap(mstatus[15:0], acc_tgt_s_s, cur_mode)};
            acc_mode_s   = acc_tgt_s_s ? PRIV_S : PRIV_M;
            if (acc_irq_s & (acc_tvec_s[1:0] == 2'b01)) begin
                acc_rpc_s = {acc_tvec_s[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, acc_code_s, 2'b00};
            end else begin
                acc_rpc_s = {acc_tvec_s[XLEN-1:2], 2'b00};
            end
        end
    end

    assign ev_ack = accept_s;

    // Next state and next registered outputs; CSR write outputs hold until the port grants
    always_comb begin
        state_nx_s = state_r;
        wen_nx_s   = csr_wen_r;
        waddr_nx_s = csr_waddr_r;
        wdata_nx_s = csr_wdata_r;
        rv_nx_s    = 1'b0;
        rpc_nx_s   = {XLEN{1'b0}};
        mode_nx_s  = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (accept_s & acc_xret_s) begin
                    state_nx_s = ST_W_STATUS;
                    wen_nx_s   = 1'b1;
                    waddr_nx_s = CSR_MSTATUS;
                    wdata_nx_s = acc_status_s;
                end else if (accept_s) begin
                    state_nx_s = ST_W_EPC;
                    wen_nx_s   = 1'b1;
                    waddr_nx_s = acc_tgt_s_s ? CSR_SEPC : CSR_MEPC;
                    wdata_nx_s = epc;
                end else begin
                    wen_nx_s   = 1'b0;
                    waddr_nx_s = 12'h000;
                    wdata_nx_s = {XLEN{1'b0}};
                end
            end
            ST_W_EPC: begin
                if (grant_s) begin
                    state_nx_s = ST_W_CAUSE;
                    waddr_nx_s = tgt_s_r ? CSR_SCAUSE : CSR_MCAUSE;
                    wdata_nx_s = cause_r;
                end else begin
                    state_nx_s = ST_W_EPC;
                end
            end
            ST_W_CAUSE: begin
                if (grant_s) begin
                    state_nx_s = ST_W_TVAL;
                    waddr_nx_s = tgt_s_r ? CSR_STVAL : CSR_MTVAL;
                    wdata_nx_s = tval_r;
                end else begin
                    state_nx_s = ST_W_CAUSE;
                end
            end
            ST_W_TVAL: begin
                if (grant_s) begin
                    state_nx_s = ST_W_STATUS;
                    waddr_nx_s = CSR_MSTATUS;
                    wdata_nx_s = status_r;
                end else begin
                    state_nx_s = ST_W_TVAL;
                end
            end
            ST_W_STATUS: begin
                if (grant_s) begin
                    state_nx_s = ST_REDIRECT;
                    wen_nx_s   = 1'b0;
                    waddr_nx_s = 12'h000;
                    wdata_nx_s = {XLEN{1'b0}};
                    rv_nx_s    = 1'b1;
                    rpc_nx_s   = rpc_r;
                    mode_nx_s  = nmode_r;
                end else begin
                    state_nx_s = ST_W_STATUS;
                end
            end
            ST_REDIRECT: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                wen_nx_s   = 1'b0;
                waddr_nx_s = 12'h000;
                wdata_nx_s = {XLEN{1'b0}};
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            busy_r           <= 1'b0;
            csr_wen_r        <= 1'b0;
            csr_waddr_r      <= 12'h000;
            csr_wdata_r      <= {XLEN{1'b0}};
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
            next_mode_r      <= 2'b00;
        end else begin
            state_r          <= state_nx_s;
            busy_r           <= (state_nx_s != ST_IDLE);
            csr_wen_r        <= wen_nx_s;
            csr_waddr_r      <= waddr_nx_s;
            csr_wdata_r      <= wdata_nx_s;
            redirect_valid_r <= rv_nx_s;
            redirect_pc_r    <= rpc_nx_s;
            next_mode_r      <= mode_nx_s;
        end
    end

    // Snapshot of the accepted event so later CSR input changes cannot disturb the sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_s_r  <= 1'b0;
            cause_r  <= {XLEN{1'b0}};
            tval_r   <= {XLEN{1'b0}};
            status_r <= {XLEN{1'b0}};
            rpc_r    <= {XLEN{1'b0}};
            nmode_r  <= 2'b00;
        end else if (accept_s) begin
            tgt_s_r  <= acc_tgt_s_s;
            cause_r  <= acc_cause_s;
            tval_r   <= acc_irq_s ? {XLEN{1'b0}} : acc_tval_s;
            status_r <= acc_status_s;
            rpc_r    <= acc_rpc_s;
            nmode_r  <= acc_mode_s;
        end else begin
            tgt_s_r  <= tgt_s_r;
        end
    end

    assign busy           = busy_r;
    assign csr_wen        = csr_wen_r;
    assign csr_waddr      = csr_waddr_r;
    assign csr_wdata      = csr_wdata_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign next_mode      = next_mode_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed vector table, stall and
// reset sequences, and randomized events against a rule-level model.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid, xret_valid, xret_is_mret, int_window;
    logic [3:0]  exc_code;
    logic [31:0] exc_tval, epc, mstatus, mtvec, stvec, mepc, sepc;
    logic [1:0]  cur_mode;
    logic [15:0] medeleg, mideleg, mip, mie;
    logic        ev_ack, busy, csr_wen, csr_wready, redirect_valid;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;
    logic [1:0]  next_mode;

    int total = 0;
    int bad   = 0;

    localparam int PRIO [6] = '{11, 3, 7, 9, 1, 5};

    typedef struct {
        bit          exc_valid, xret_valid, xret_is_mret, int_window;
        logic [3:0]  exc_code;
        logic [31:0] exc_tval, epc, mstatus, mtvec, stvec, mepc, sepc;
        logic [1:0]  cur_mode;
        logic [15:0] medeleg, mideleg, mip, mie;
    } ev_t;

    typedef struct {
        bit               ack;
        int               nw;
        logic [3:0][11:0] addr;
        logic [3:0][31:0] data;
        logic [31:0]      rpc;
        logic [1:0]       mode;
    } exp_t;

    typedef struct {
        ev_t  ev;
        exp_t ex;
    } vec_t;

    vec_t  tbl [9];
    string tname [9];

    trap_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
        .xret_valid(xret_valid), .xret_is_mret(xret_is_mret), .int_window(int_window),
        .epc(epc), .cur_mode(cur_mode), .mstatus(mstatus), .mtvec(mtvec), .stvec(stvec),
        .mepc(mepc), .sepc(sepc), .medeleg(medeleg), .mideleg(mideleg), .mip(mip), .mie(mie),
        .ev_ack(ev_ack), .busy(busy), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_wready(csr_wready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .next_mode(next_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t ev_zero();
        ev_t z;
        z = '{default: '0};
        return z;
    endfunction

    function automatic exp_t mk_none();
        exp_t x;
        x.ack = 1'b0; x.nw = 0; x.addr = '0; x.data = '0; x.rpc = 32'h0; x.mode = 2'd0;
        return x;
    endfunction

    function automatic exp_t mk_trap(input logic [11:0] base, input logic [31:0] epc_v,
                                     input logic [31:0] cause, input logic [31:0] tval_v,
                                     input logic [31:0] st, input logic [31:0] pc,
                                     input logic [1:0] md);
        exp_t x;
        x = mk_none();
        x.ack = 1'b1; x.nw = 4;
        x.addr[0] = base + 12'h041; x.data[0] = epc_v;
        x.addr[1] = base + 12'h042; x.data[1] = cause;
        x.addr[2] = base + 12'h043; x.data[2] = tval_v;
        x.addr[3] = 12'h300;        x.data[3] = st;
        x.rpc = pc; x.mode = md;
        return x;
    endfunction

    function automatic exp_t mk_xret(input logic [31:0] st, input logic [31:0] pc, input logic [1:0] md);
        exp_t x;
        x = mk_none();
        x.ack = 1'b1; x.nw = 1;
        x.addr[0] = 12'h300; x.data[0] = st;
        x.rpc = pc; x.mode = md;
        return x;
    endfunction

    // Rule-level reference: what the architecture says should happen for one event
    function automatic exp_t model(input ev_t e);
        exp_t x;
        bit trap, irq, to_s, ok;
        int code, b;
        logic [31:0] tval_v, st, tvec, stn, cause;
        x = mk_none();
        trap = 0; irq = 0; to_s = 0; code = 0; tval_v = 32'h0;
        st = e.mstatus;
        if (e.exc_valid) begin
            trap = 1; code = e.exc_code; tval_v = e.exc_tval;
        end else if (e.xret_valid) begin
            if (e.xret_is_mret ? (e.cur_mode != 2'd3) : (e.cur_mode == 2'd0)) begin
                trap = 1; code = 2;
            end else if (e.xret_is_mret) begin
                stn = (st & ~32'h0000_1888) | (32'(st[7]) << 3) | 32'h80;
                x = mk_xret(stn, e.mepc, st[12:11]);
            end else begin
                stn = (st & ~32'h0000_0122) | (32'(st[5]) << 1) | 32'h20;
                x = mk_xret(stn, e.sepc, {1'b0, st[8]});
            end
        end else if (e.int_window) begin
            foreach (PRIO[i]) begin
                b = PRIO[i];
                if (!irq && e.mip[b] && e.mie[b]) begin
                    ok = e.mideleg[b] ? (e.cur_mode == 2'd0 || (e.cur_mode == 2'd1 && st[1]))
                                      : (e.cur_mode != 2'd3 || st[3]);
                    if (ok) begin
                        irq = 1; trap = 1; code = b; to_s = e.mideleg[b];
                    end
                end
            end
        end
        if (trap) begin
            if (!irq) to_s = (e.cur_mode != 2'd3) && e.medeleg[code];
            cause = irq ? (32'h8000_0000 | 32'(code)) : 32'(code);
            if (to_s) stn = (st & ~32'h0000_0122) | (32'(st[1]) << 5) | (32'(e.cur_mode[0]) << 8);
            else      stn = (st & ~32'h0000_1888) | (32'(st[3]) << 7) | (32'(e.cur_mode) << 11);
            tvec = to_s ? e.stvec : e.mtvec;
            x = mk_trap(to_s ? 12'h100 : 12'h300, e.epc, cause, irq ? 32'h0 : tval_v, stn,
                        (tvec & ~32'h3) + ((irq && tvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0),
                        to_s ? 2'd1 : 2'd3);
        end
        return x;
    endfunction

    task automatic drive(input ev_t e);
        exc_valid = e.exc_valid; xret_valid = e.xret_valid; xret_is_mret = e.xret_is_mret;
        int_window = e.int_window; exc_code = e.exc_code; exc_tval = e.exc_tval; epc = e.epc;
        mstatus = e.mstatus; mtvec = e.mtvec; stvec = e.stvec; mepc = e.mepc; sepc = e.sepc;
        cur_mode = e.cur_mode; medeleg = e.medeleg; mideleg = e.mideleg; mip = e.mip; mie = e.mie;
    endtask

    task automatic clear_valids();
        exc_valid = 1'b0; xret_valid = 1'b0; int_window = 1'b0;
    endtask

    task automatic scramble();
        exc_valid = 1'($urandom); xret_valid = 1'($urandom); int_window = 1'($urandom);
        xret_is_mret = 1'($urandom); exc_code = 4'($urandom); exc_tval = $urandom; epc = $urandom;
        mstatus = $urandom; mtvec = $urandom; stvec = $urandom; mepc = $urandom; sepc = $urandom;
        cur_mode = 2'($urandom); medeleg = 16'($urandom); mideleg = 16'($urandom);
        mip = 16'($urandom); mie = 16'($urandom);
    endtask

    // Apply one event, follow the write sequence to the redirect and compare with x
    task automatic run_event(input string name, input ev_t e, input exp_t x,
                             input int stall_idx, input int stall_len, input bit noisy);
        int nw, stalled, cyc;
        bit done, holding;
        logic [3:0][11:0] oa;
        logic [3:0][31:0] od;
        logic [11:0] hold_a;
        logic [31:0] hold_d;
        nw = 0; stalled = 0; cyc = 0; done = 0; holding = 0; oa = '0; od = '0;
        hold_a = 12'h0; hold_d = 32'h0;
        @(negedge clk);
        drive(e);
        csr_wready = 1'b1;
        #1;
        check({name, " ev_ack"}, ev_ack, x.ack);
        check({name, " idle busy"}, busy, 1'b0);
        check({name, " idle redirect"}, redirect_valid, 1'b0);
        if (!x.ack) begin
            repeat (2) begin
                @(negedge clk);
                clear_valids();
                #1;
                check({name, " no-event busy"}, busy, 1'b0);
                check({name, " no-event wen"}, csr_wen, 1'b0);
            end
        end else begin
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (noisy) scramble();
                else clear_valids();
                csr_wready = 1'b1;
                if (csr_wen && nw == stall_idx && stalled < stall_len) begin
                    csr_wready = 1'b0;
                    stalled++;
                end
                #1;
                check({name, " busy"}, busy, 1'b1);
                check({name, " ack while busy"}, ev_ack, 1'b0);
                if (csr_wen) begin
                    if (holding) begin
                        check({name, " stall addr"}, csr_waddr, hold_a);
                        check({name, " stall data"}, csr_wdata, hold_d);
                    end
                    if (csr_wready) begin
                        if (nw < 4) begin
                            oa[nw] = csr_waddr;
                            od[nw] = csr_wdata;
                        end
                        nw++;
                        holding = 0;
                    end else begin
                        hold_a = csr_waddr; hold_d = csr_wdata; holding = 1;
                    end
                end
                if (redirect_valid) begin
                    done = 1;
                    check({name, " redirect_pc"}, redirect_pc, x.rpc);
                    check({name, " next_mode"}, next_mode, x.mode);
                    check({name, " redirect cycle"}, cyc, x.nw + 1 + stall_len);
                    check({name, " wen at redirect"}, csr_wen, 1'b0);
                end
            end
            check({name, " redirect seen"}, done, 1'b1);
            check({name, " stall cycles"}, stalled, stall_len);
            check({name, " write count"}, nw, x.nw);
            for (int i = 0; i < x.nw; i++) begin
                check({name, " waddr"}, oa[i], x.addr[i]);
                check({name, " wdata"}, od[i], x.data[i]);
            end
        end
    endtask

    initial begin
        ev_t  e;
        exp_t x;
        bit   reached;
        int   sel, sidx, slen;

        rst_n = 1'b0;
        csr_wready = 1'b1;
        drive(ev_zero());

        // Directed vectors
        e = ev_zero(); e.exc_valid = 1; e.exc_code = 4'd2; e.epc = 32'h100; e.exc_tval = 32'h13;
        e.mtvec = 32'h8000_0000; e.mstatus = 32'h8; e.cur_mode = 2'd0;
        tname[0] = "illegal_from_U"; tbl[0].ev = e;
        tbl[0].ex = mk_trap(12'h300, 32'h100, 32'h2, 32'h13, 32'h80, 32'h8000_0000, 2'd3);

        e = ev_zero(); e.exc_valid = 1; e.exc_code = 4'd8; e.epc = 32'h200; e.medeleg = 16'h0100;
        e.stvec = 32'h4000; e.mstatus = 32'h2; e.cur_mode = 2'd0;
        tname[1] = "deleg_ecall_U"; tbl[1].ev = e;
        tbl[1].ex = mk_trap(12'h100, 32'h200, 32'h8, 32'h0, 32'h20, 32'h4000, 2'd1);

        e = ev_zero(); e.int_window = 1; e.cur_mode = 2'd3; e.mstatus = 32'h8; e.mip = 16'h0880;
        e.mie = 16'h0880; e.mtvec = 32'h1001; e.epc = 32'h300;
        tname[2] = "vectored_MEI"; tbl[2].ev = e;
        tbl[2].ex = mk_trap(12'h300, 32'h300, 32'h8000_000B, 32'h0, 32'h1880, 32'h102C, 2'd3);

        e = ev_zero(); e.xret_valid = 1; e.xret_is_mret = 1; e.cur_mode = 2'd3;
        e.mstatus = 32'h880; e.mepc = 32'h200;
        tname[3] = "mret"; tbl[3].ev = e;
        tbl[3].ex = mk_xret(32'h88, 32'h200, 2'd1);

        e = ev_zero(); e.xret_valid = 1; e.xret_is_mret = 0; e.cur_mode = 2'd0; e.epc = 32'h404;
        e.mtvec = 32'h8000_0100; e.mstatus = 32'h8; e.sepc = 32'h999;
        tname[4] = "sret_from_U"; tbl[4].ev = e;
        tbl[4].ex = mk_trap(12'h300, 32'h404, 32'h2, 32'h0, 32'h80, 32'h8000_0100, 2'd3);

        e = ev_zero(); e.exc_valid = 1; e.xret_valid = 1; e.xret_is_mret = 1; e.cur_mode = 2'd3;
        e.exc_code = 4'd5; e.exc_tval = 32'h55; e.epc = 32'h500; e.mtvec = 32'h2000;
        e.mstatus = 32'h1808; e.mepc = 32'h777;
        tname[5] = "exc_over_xret"; tbl[5].ev = e;
        tbl[5].ex = mk_trap(12'h300, 32'h500, 32'h5, 32'h55, 32'h1880, 32'h2000, 2'd3);

        e = ev_zero(); e.xret_valid = 1; e.xret_is_mret = 0; e.cur_mode = 2'd1;
        e.mstatus = 32'h120; e.sepc = 32'h600;
        tname[6] = "sret_from_S"; tbl[6].ev = e;
        tbl[6].ex = mk_xret(32'h22, 32'h600, 2'd1);

        e = ev_zero(); e.int_window = 1; e.cur_mode = 2'd1; e.mstatus = 32'h2; e.mip = 16'h0200;
        e.mie = 16'h0200; e.mideleg = 16'h0200; e.stvec = 32'h3001; e.epc = 32'h700;
        tname[7] = "deleg_SEI_vec"; tbl[7].ev = e;
        tbl[7].ex = mk_trap(12'h100, 32'h700, 32'h8000_0009, 32'h0, 32'h120, 32'h3024, 2'd1);

        e = ev_zero(); e.int_window = 1; e.cur_mode = 2'd3; e.mstatus = 32'h0;
        e.mip = 16'h0080; e.mie = 16'h0080;
        tname[8] = "masked_irq_M"; tbl[8].ev = e;
        tbl[8].ex = mk_none();

        // Reset values
        #12;
        check("reset ev_ack", ev_ack, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset csr_wen", csr_wen, 1'b0);
        check("reset csr_waddr", csr_waddr, 12'h0);
        check("reset csr_wdata", csr_wdata, 32'h0);
        check("reset redirect_valid", redirect_valid, 1'b0);
        check("reset redirect_pc", redirect_pc, 32'h0);
        check("reset next_mode", next_mode, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_event(tname[i], tbl[i].ev, tbl[i].ex, -1, 0, 1'b0);

        // Grant withheld for three cycles while MCAUSE is pending
        run_event("stall_W_CAUSE", tbl[0].ev, tbl[0].ex, 1, 3, 1'b0);

        // Reset while the MTVAL write is pending
        @(negedge clk);
        drive(tbl[0].ev);
        csr_wready = 1'b1;
        reached = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            clear_valids();
            #1;
            if (csr_wen && csr_waddr == 12'h343) begin
                reached = 1;
                break;
            end
        end
        check("reached W_TVAL", reached, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("midreset ev_ack", ev_ack, 1'b0);
        check("midreset busy", busy, 1'b0);
        check("midreset csr_wen", csr_wen, 1'b0);
        check("midreset csr_waddr", csr_waddr, 12'h0);
        check("midreset csr_wdata", csr_wdata, 32'h0);
        check("midreset redirect_valid", redirect_valid, 1'b0);
        check("midreset redirect_pc", redirect_pc, 32'h0);
        check("midreset next_mode", next_mode, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post-reset wen", csr_wen, 1'b0);
            check("post-reset redirect", redirect_valid, 1'b0);
            check("post-reset busy", busy, 1'b0);
        end
        run_event("after_reset", tbl[0].ev, tbl[0].ex, -1, 0, 1'b0);

        // Randomized events, back to back, with CSR noise during busy and random stalls
        for (int n = 0; n < 150; n++) begin
            e = ev_zero();
            sel = $urandom_range(0, 3);
            e.exc_valid    = (sel == 0) || (sel == 3 && $urandom_range(0, 1) == 1);
            e.xret_valid   = (sel == 1) || (sel == 3 && $urandom_range(0, 1) == 1);
            e.int_window   = (sel == 2) || ($urandom_range(0, 3) == 0);
            e.xret_is_mret = 1'($urandom);
            sel = $urandom_range(0, 2);
            e.cur_mode = (sel == 2) ? 2'd3 : 2'(sel);
            e.exc_code = 4'($urandom); e.exc_tval = $urandom; e.epc = $urandom;
            e.mstatus = $urandom; e.mtvec = $urandom; e.stvec = $urandom;
            e.mepc = $urandom; e.sepc = $urandom;
            e.medeleg = 16'($urandom); e.mideleg = 16'($urandom);
            e.mip = 16'($urandom) & 16'($urandom); e.mie = 16'($urandom) | 16'($urandom);
            x = model(e);
            sidx = $urandom_range(0, 3);
            slen = (sidx < x.nw) ? $urandom_range(0, 2) : 0;
            run_event("random", e, x, sidx, slen, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
